key_event_sched: RTL

Keyboard event scheduler between the HPS `ps2_key` input and the Spectrum `keyboard` matrix block. It shares the keyboard's single 11-bit toggle-strobed event port between two sources: live PS/2 events and a macro player. The macro player replays scripted key press/release sequences, such as auto-typing `LOAD ""` + ENTER, from a script ROM at a fixed step rate. Live events arriving while a macro runs are buffered and forwarded afterwards. An ESC press aborts the macro safely.

---
 rtl/kbd_pkg.sv | 56 +++++
 rtl/key_event_sched_if.sv | 39 +++
 rtl/kev_fifo.sv | 67 ++++++
 rtl/key_event_sched.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// -----------------------------------------------------------------------------
// kbd_pkg
// Shared types and constants for the keyboard event scheduler.
//   MACRO_PAUSE / MACRO_END : special 9-bit script entries {rel, code}
//   KEY_ESC                 : scancode that aborts a running macro
//   kev_t                   : 10-bit key event (pressed, ext, code)
//   sched_state_t           : scheduler FSM state, also exported for debug
//   DEFAULT_ROM             : default script image, 64 entries x 9 bits,
//                             entry i at bits [i*9 +: 9]
// -----------------------------------------------------------------------------
package kbd_pkg;

  localparam logic [8:0] MACRO_PAUSE = 9'h000;
  localparam logic [8:0] MACRO_END   = 9'h1FF;
  localparam logic [7:0] KEY_ESC     = 8'h76;

  localparam int DEFAULT_ROM_DEPTH = 64;

  typedef struct packed {
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } kev_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP  = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_t;

  // Address 0: tap F10 (auto-load shortcut on the core).
  // Address 4: type J (LOAD keyword), shift+' twice ("" in PS/2 layout), ENTER.
  // Every unused entry is an end marker so a stray start_addr stops at once.
  function automatic logic [DEFAULT_ROM_DEPTH*9-1:0] default_rom();
    logic [DEFAULT_ROM_DEPTH*9-1:0] img;
    img = '1;
    img[0*9  +: 9] = 9'h009;
    img[1*9  +: 9] = 9'h109;
    img[2*9  +: 9] = MACRO_END;
    img[4*9  +: 9] = 9'h03B;
    img[5*9  +: 9] = 9'h13B;
    img[6*9  +: 9] = 9'h012;
    img[7*9  +: 9] = 9'h052;
    img[8*9  +: 9] = 9'h152;
    img[9*9  +: 9] = 9'h052;
    img[10*9 +: 9] = 9'h152;
    img[11*9 +: 9] = 9'h112;
    img[12*9 +: 9] = 9'h05A;
    img[13*9 +: 9] = 9'h15A;
    img[14*9 +: 9] = MACRO_END;
    return img;
  endfunction

  localparam logic [DEFAULT_ROM_DEPTH*9-1:0] DEFAULT_ROM = default_rom();

endpackage

// File: rtl/key_event_sched_if.sv
// -----------------------------------------------------------------------------
// key_event_sched_if
// Bundles the scheduler's event ports.
//   ps2_key_in  : live event from the HPS, [10] toggle strobe, [9] pressed,
//                 [8] extended, [7:0] scancode
//   start       : one-cycle pulse starting the macro at start_addr
//   start_addr  : first script entry
//   ps2_key_out : event towards the keyboard matrix, same format as input
//   busy        : macro running or buffered live events pending
//   overflow    : sticky, a live event was dropped
//   dbg_state   : current scheduler FSM state
// Event handshake: there is no valid/ready pair. A producer publishes a new
// event by updating bits [9:0] and inverting bit [10] in the same cycle; the
// consumer treats any change of bit [10] as exactly one event and cannot
// apply back-pressure, so at most one event can be carried per cycle.
// -----------------------------------------------------------------------------
interface key_event_sched_if
  import kbd_pkg::*;
#(
  parameter int AW = 6
);
  logic [10:0]   ps2_key_in;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [10:0]   ps2_key_out;
  logic          busy;
  logic          overflow;
  sched_state_t  dbg_state;

  modport master (
    output ps2_key_in, start, start_addr,
    input  ps2_key_out, busy, overflow, dbg_state
  );

  modport slave (
    input  ps2_key_in, start, start_addr,
    output ps2_key_out, busy, overflow, dbg_state
  );
endinterface

// File: rtl/kev_fifo.sv
// -----------------------------------------------------------------------------
// kev_fifo
// 4-deep FIFO of kev_t events.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data (accepted if not full, or if popping too)
//   push_data  : event to store
//   pop        : remove the head entry (ignored when empty)
//   pop_data   : head entry, valid while not empty
//   full/empty : occupancy flags
//   count      : occupancy 0..4
// -----------------------------------------------------------------------------
module kev_fifo
  import kbd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  kev_t       push_data,
  input  logic       pop,
  output kev_t       pop_data,
  output logic       full,
  output logic       empty,
  output logic [2:0] count
);

  kev_t       mem_q [4];
  kev_t       mem_d [4];
  logic [1:0] wr_q, wr_d;
  logic [1:0] rd_q, rd_d;
  logic [2:0] cnt_q, cnt_d;
  logic       do_push;
  logic       do_pop;

  assign full     = (cnt_q == 3'd4);
  assign empty    = (cnt_q == 3'd0);
  assign count    = cnt_q;
  assign pop_data = mem_q[rd_q];

  always_comb begin
    do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q] = push_data;
    wr_d  = wr_q + 2'(do_push);
    rd_d  = rd_q + 2'(do_pop);
    cnt_d = cnt_q + 3'(do_push) - 3'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= 2'd0;
      rd_q  <= 2'd0;
      cnt_q <= 3'd0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/key_event_sched.sv
// -----------------------------------------------------------------------------
// key_event_sched
// Shares the keyboard's toggle-strobed event port between live PS/2 events
// and a macro player replaying a script ROM at a fixed step rate. Live events
// seen while a macro runs are buffered and forwarded after it; an ESC press
// during a macro aborts it once every macro-pressed key has been released.
//   clk_sys, reset : system clock, synchronous active-high reset
//   bus (slave)    : ps2_key_in, start, start_addr in;
//                    ps2_key_out, busy, overflow, dbg_state out
// Parameters:
//   STEP_CYCLES : clock cycles between macro steps
//   ROM_DEPTH   : script entries (power of two)
//   ROM_INIT    : script image, entry i at bits [i*9 +: 9]
// -----------------------------------------------------------------------------
module key_event_sched
  import kbd_pkg::*;
#(
  parameter int unsigned            STEP_CYCLES = 7000000,
  parameter int unsigned            ROM_DEPTH   = 64,
  parameter logic [ROM_DEPTH*9-1:0] ROM_INIT    = (ROM_DEPTH*9)'(DEFAULT_ROM)
)(
  input  logic          clk_sys,
  input  logic          reset,
  key_event_sched_if.slave bus
);

  localparam int AW = $clog2(ROM_DEPTH);
  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0] TERM = TW'(STEP_CYCLES - 1);

  sched_state_t  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW:0]   pc_q, pc_d;
  logic [2:0]    held_q, held_d;
  logic          abort_q, abort_d;
  logic          ovf_q, ovf_d;
  logic [10:0]   out_q, out_d;
  logic          prev_tog_q, prev_tog_d;

  logic          toggle;
  kev_t          live_ev;
  logic          is_esc;
  logic [8:0]    rom_entry;
  kev_t          macro_ev;

  logic          f_push;
  logic          f_pop;
  kev_t          f_pop_data;
  logic          f_full;
  logic          f_empty;
  logic [2:0]    f_count;

  kev_fifo u_fifo (
    .clk       (clk_sys),
    .rst       (reset),
    .push      (f_push),
    .push_data (live_ev),
    .pop       (f_pop),
    .pop_data  (f_pop_data),
    .full      (f_full),
    .empty     (f_empty),
    .count     (f_count)
  );

  assign bus.ps2_key_out = out_q;
  assign bus.busy        = (state_q != ST_IDLE) || (f_count != 3'd0);
  assign bus.overflow    = ovf_q;
  assign bus.dbg_state   = state_q;

  always_comb begin
    toggle     = bus.ps2_key_in[10] ^ prev_tog_q;
    prev_tog_d = bus.ps2_key_in[10];
    live_ev    = kev_t'(bus.ps2_key_in[9:0]);
    is_esc     = live_ev.pressed & ~live_ev.ext & (live_ev.code == KEY_ESC);

    // pc == ROM_DEPTH (top bit set) reads as an end marker.
    rom_entry = pc_q[AW] ? MACRO_END : ROM_INIT[pc_q[AW-1:0]*9 +: 9];
    macro_ev.pressed = ~rom_entry[8];
    macro_ev.ext     = 1'b0;
    macro_ev.code    = rom_entry[7:0];

    state_d = state_q;
    timer_d = timer_q;
    pc_d    = pc_q;
    held_d  = held_q;
    abort_d = abort_q;
    ovf_d   = ovf_q;
    out_d   = out_q;
    f_push  = 1'b0;
    f_pop   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Leftover buffered events go first; a new live event then queues
        // behind them so ordering is kept.
        if (!f_empty) begin
          f_pop = 1'b1;
          out_d = {~out_q[10], f_pop_data};
          if (toggle) f_push = 1'b1;
        end else if (toggle) begin
          out_d = {~out_q[10], live_ev};
        end
        if (bus.start) begin
          state_d = ST_STEP;
          pc_d    = {1'b0, bus.start_addr};
          timer_d = '0;
          held_d  = 3'd0;
          abort_d = 1'b0;
          ovf_d   = 1'b0;
        end
      end

      ST_STEP: begin
        if (toggle) begin
          if (is_esc) abort_d = 1'b1;
          else        f_push  = 1'b1;
        end
        if (timer_q == TERM) begin
          timer_d = '0;
          // Abort only once no macro key is left pressed, so the keyboard
          // never sees a stuck key.
          if (abort_q && (held_q == 3'd0)) begin
            state_d = ST_DRAIN;
          end else if (rom_entry == MACRO_END) begin
            state_d = ST_DRAIN;
          end else if (rom_entry == MACRO_PAUSE) begin
            pc_d = pc_q + (AW+1)'(1);
          end else begin
            out_d = {~out_q[10], macro_ev};
            pc_d  = pc_q + (AW+1)'(1);
            if (rom_entry[8]) begin
              if (held_q != 3'd0) held_d = held_q - 3'd1;
            end else begin
              if (held_q != 3'd7) held_d = held_q + 3'd1;
            end
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_DRAIN: begin
        if (toggle) f_push = 1'b1;
        if (!f_empty) begin
          f_pop = 1'b1;
          out_d = {~out_q[10], f_pop_data};
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (f_push && f_full && !f_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      pc_q       <= '0;
      held_q     <= 3'd0;
      abort_q    <= 1'b0;
      ovf_q      <= 1'b0;
      out_q      <= 11'd0;
      // Track the live strobe through reset so no phantom event follows.
      prev_tog_q <= bus.ps2_key_in[10];
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pc_q       <= pc_d;
      held_q     <= held_d;
      abort_q    <= abort_d;
      ovf_q      <= ovf_d;
      out_q      <= out_d;
      prev_tog_q <= prev_tog_d;
    end
  end

endmodule
